mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, RAM address width in bits.
REQ-002 Parameter DATA_W, 32, RAM data word width in bits.
REQ-003 Parameter DMAX, 4, maximum consecutive data grants while an instruction request waits; valid range 1..15.
REQ-004 Parameter TIMEOUT, 16, cycles a grant may wait for RAM ACCESS before being aborted; valid range 2..255.
REQ-005 CLK  in  1  system clock; all state updates on the rising edge.
REQ-006 nRST  in  1  reset, synchronous, active-high (1 = reset).
REQ-007 iREN  in  1  instruction fetch request; held until ihit.
REQ-008 iaddr  in  ADDR_W  instruction fetch address.
REQ-009 ihit  out  1  instruction fetch complete, one-cycle pulse.
REQ-010 iload  out  DATA_W  fetched instruction word; valid only while ihit=1.
REQ-011 dREN  in  1  data read request; held until dhit.
REQ-012 dWEN  in  1  data write request; held until dhit.
REQ-013 daddr  in  ADDR_W  data address.
REQ-014 dstore  in  DATA_W  data write word.
REQ-015 dhit  out  1  data access complete, one-cycle pulse.
REQ-016 dload  out  DATA_W  data read word; valid only while dhit=1.
REQ-017 ramREN  out  1  RAM read enable.
REQ-018 ramWEN  out  1  RAM write enable.
REQ-019 ramaddr  out  ADDR_W  RAM address.
REQ-020 ramstore  out  DATA_W  RAM write data.
REQ-021 ramload  in  DATA_W  RAM read data.
REQ-022 ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-023 memerr  out  1  one-cycle pulse on RAM ERROR or timeout abort.

Function
REQ-024 States: IDLE, IGNT, DGNT, ERR; the state is registered.
REQ-025 Data request: dreq = dREN | dWEN; dWEN takes precedence when both are high, so the access is a write.
REQ-026 IDLE: if dreq and (dstreak < DMAX or !iREN), next state is DGNT; else if iREN, next state is IGNT; else the state stays IDLE.
REQ-027 IDLE drives ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, ihit=0, dhit=0.
REQ-028 IGNT drives ramREN=1, ramWEN=0, ramaddr=iaddr.
REQ-029 DGNT drives ramREN=dREN&!dWEN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
REQ-030 In a grant state, ramstate=ACCESS combinationally asserts the granted port's hit, passes ramload to iload or dload, and sets next state IDLE.
REQ-031 Minimum latency: request seen in IDLE at cycle N, hit at cycle N+1 if RAM returns ACCESS immediately; at least one IDLE cycle separates successive grants.
REQ-032 If the granted request drops before ACCESS, the grant is aborted: next state IDLE, no hit, RAM enables deassert next cycle.
REQ-033 Wait counter: cleared on entry to a grant state and incremented each grant cycle without ACCESS.
REQ-034 ramstate=ERROR, or the wait counter reaching TIMEOUT-1 without ACCESS, moves the arbiter to ERR with no hit.
REQ-035 ERR lasts exactly one cycle: memerr=1, RAM enables=0, next state IDLE; the requester retries by holding its request.
REQ-036 dstreak (4-bit) increments on each dhit while iREN=1, saturating at DMAX.
REQ-037 dstreak clears on ihit, or in any cycle with iREN=0.
REQ-038 Simultaneous iREN and dreq in IDLE with dstreak < DMAX: data wins.
REQ-039 iload and dload are 0 whenever the corresponding hit is 0.

Reset
REQ-040 nRST=1 at a rising edge forces IDLE and clears dstreak and the wait counter.
REQ-041 During and after reset, all outputs are 0 until the first non-reset edge.
REQ-042 Reset asserted mid-grant deasserts ramREN/ramWEN on the next edge with no hit or memerr pulse.

Verification
REQ-043 Instruction fetch: iREN=1, iaddr=0x40, RAM BUSY 2 cycles then ACCESS with ramload=0x2001000A -> ihit=1 for one cycle, iload=0x2001000A, ramREN=1 for exactly 3 cycles.
REQ-044 Simultaneous requests: iREN=1, dREN=1, both at ACCESS immediately -> dhit precedes ihit; ihit arrives 2 cycles after dhit.
REQ-045 Fairness: iREN held and dREN held for 10 accesses, DMAX=4 -> grant order D,D,D,D,I, then data wins the next grant.
REQ-046 Write: dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramaddr=0x100, ramstore=0xDEADBEEF, then dhit=1 on ACCESS.
REQ-047 Timeout and error: ramstate stuck BUSY with TIMEOUT=16 -> memerr pulses 17 cycles after the grant and no hit occurs; ramstate=ERROR -> memerr on the next cycle.
REQ-048 Reset mid-grant: nRST=1 during DGNT -> all outputs 0 next cycle, state IDLE, dstreak=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port RAM arbiter: instruction fetch and data access share one RAM.
// Data is favoured, but a waiting fetch is granted after DMAX data hits.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DMAX    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              memerr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [3:0] DMAX_C     = 4'(DMAX);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [3:0] dstreak_q, dstreak_d;
    logic       dreq;

    assign dreq = dREN | dWEN;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        ihit     = 1'b0;
        iload    = '0;
        dhit     = 1'b0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        memerr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                wait_d = '0;
                if (dreq && (dstreak_q < DMAX_C || !iREN)) begin
                    state_d = DGNT;
                end else if (iREN) begin
                    state_d = IGNT;
                end
            end
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    ihit    = 1'b1;
                    iload   = ramload;
                    state_d = IDLE;
                end else if (ramstate == RAM_ERROR || wait_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DGNT: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    dhit    = 1'b1;
                    dload   = ramload;
                    state_d = IDLE;
                end else if (ramstate == RAM_ERROR || wait_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ERR: begin
                memerr  = 1'b1;
                wait_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Streak only matters while a fetch is actually waiting.
    always_comb begin
        dstreak_d = dstreak_q;
        if (!iREN || ihit) begin
            dstreak_d = '0;
        end else if (dhit && dstreak_q < DMAX_C) begin
            dstreak_d = dstreak_q + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            dstreak_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            dstreak_q <= dstreak_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester queues, a latency RAM model,
// and expected hits queued at stimulus time and popped on each hit.
module tb_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic        both;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        nRST, iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        ihit, dhit, ramREN, ramWEN, memerr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .DMAX(4), .TIMEOUT(16)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    logic [31:0] iq[$];
    dreq_t       dq[$];
    exp_t        sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ren_cnt, wen_cnt, err_cnt;
    int last_ihit, last_dhit, last_err;
    int mode = 0;
    int lat  = 0;
    int bcnt = 0;
    int t0;
    logic [31:0] w_addr, w_data;
    logic        w_ren;
    logic        s_ihit = 1'b0;
    logic        s_dhit = 1'b0;
    logic        s_err  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h2001000A;
        return a ^ 32'h5A5A_1234;
    endfunction

    function automatic dreq_t mkd(input logic we, input logic both,
                                  input logic [31:0] a, input logic [31:0] w);
        dreq_t r;
        r.we = we; r.both = both; r.addr = a; r.wdata = w;
        return r;
    endfunction

    function automatic exp_t mke(input logic is_d, input logic [31:0] d);
        exp_t r;
        r.is_d = is_d; r.data = d;
        return r;
    endfunction

    task automatic clr();
        ren_cnt = 0; wen_cnt = 0; err_cnt = 0;
        last_ihit = -1; last_dhit = -1; last_err = -1;
        w_addr = '0; w_data = '0; w_ren = 1'b0;
    endtask

    task automatic tick();
        exp_t e;
        @(posedge CLK);
        cyc++;
        #1;
        if (s_ihit && iq.size() > 0) iq.delete(0);
        if (s_dhit && dq.size() > 0) dq.delete(0);
        if (s_err) begin
            if (dq.size() > 0) dq.delete(0);
            else if (iq.size() > 0) iq.delete(0);
        end
        iREN  = iq.size() > 0;
        iaddr = iREN ? iq[0] : '0;
        if (dq.size() > 0) begin
            dWEN   = dq[0].we;
            dREN   = !dq[0].we || dq[0].both;
            daddr  = dq[0].addr;
            dstore = dq[0].wdata;
        end else begin
            dWEN = 1'b0; dREN = 1'b0; daddr = '0; dstore = '0;
        end
        #1;
        ramload = $urandom;
        if (ramREN || ramWEN) begin
            if (mode == 2) begin
                ramstate = 2'd3;
            end else if (mode == 0 && bcnt >= lat) begin
                ramstate = 2'd2;
                ramload  = ram_word(ramaddr);
            end else begin
                ramstate = 2'd1;
                bcnt++;
            end
        end else begin
            ramstate = 2'd0;
            bcnt = 0;
        end
        @(negedge CLK);
        s_ihit = ihit; s_dhit = dhit; s_err = memerr;
        if (ramREN) ren_cnt++;
        if (ramWEN) begin
            wen_cnt++; w_addr = ramaddr; w_data = ramstore; w_ren = ramREN;
        end
        if (memerr) begin err_cnt++; last_err = cyc; end
        chk("one_hit", 32'(ihit & dhit), 32'd0);
        if (!ihit) chk("iload_gate", iload, 32'd0);
        if (!dhit) chk("dload_gate", dload, 32'd0);
        if (ihit || dhit) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("hit_port", 32'(dhit), 32'(e.is_d));
                chk("hit_data", dhit ? dload : iload, e.data);
            end
            if (ihit) last_ihit = cyc;
            if (dhit) last_dhit = cyc;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((iq.size() + dq.size() + sb.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain", 32'(iq.size() + dq.size() + sb.size()), 32'd0);
        repeat (2) tick();
    endtask

    initial begin
        nRST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = 2'd0;
        clr();
        repeat (2) tick();
        chk("rst_ctl", 32'({ramREN, ramWEN, ihit, dhit, memerr}), 32'd0);
        chk("rst_addr", ramaddr, 32'd0);
        chk("rst_store", ramstore, 32'd0);
        chk("rst_load", iload | dload, 32'd0);
        nRST = 1'b0;
        tick();

        // fetch with two BUSY cycles
        clr(); lat = 2;
        iq.push_back(32'h40);
        sb.push_back(mke(1'b0, 32'h2001000A));
        t0 = cyc + 1;
        drain(40);
        chk("if_ren_cycles", 32'(ren_cnt), 32'd3);
        chk("if_latency", 32'(last_ihit - t0), 32'd3);

        // plain write
        clr(); lat = 0;
        dq.push_back(mkd(1'b1, 1'b0, 32'h100, 32'hDEADBEEF));
        sb.push_back(mke(1'b1, ram_word(32'h100)));
        t0 = cyc + 1;
        drain(40);
        chk("wr_wen_cycles", 32'(wen_cnt), 32'd1);
        chk("wr_addr", w_addr, 32'h100);
        chk("wr_data", w_data, 32'hDEADBEEF);
        chk("wr_ren", 32'(w_ren), 32'd0);
        chk("wr_latency", 32'(last_dhit - t0), 32'd1);

        // dREN and dWEN together must still be a write
        clr();
        dq.push_back(mkd(1'b1, 1'b1, 32'h104, 32'h12345678));
        sb.push_back(mke(1'b1, ram_word(32'h104)));
        drain(40);
        chk("both_wen", 32'(wen_cnt), 32'd1);
        chk("both_ren", 32'(w_ren), 32'd0);
        chk("both_data", w_data, 32'h12345678);

        // simultaneous requests: data first, fetch two cycles later
        clr();
        iq.push_back(32'h200);
        dq.push_back(mkd(1'b0, 1'b0, 32'h300, 32'h0));
        sb.push_back(mke(1'b1, ram_word(32'h300)));
        sb.push_back(mke(1'b0, ram_word(32'h200)));
        t0 = cyc + 1;
        drain(40);
        chk("sim_dhit", 32'(last_dhit - t0), 32'd1);
        chk("sim_gap", 32'(last_ihit - last_dhit), 32'd2);

        // fairness: D x4, I, D x4, I, D x2
        clr(); lat = 1;
        for (int k = 0; k < 10; k++)
            dq.push_back(mkd(1'b0, 1'b0, 32'h1000 + 32'(4 * k), 32'h0));
        iq.push_back(32'h2000);
        iq.push_back(32'h2004);
        for (int k = 0; k < 12; k++) begin
            if (k == 4) sb.push_back(mke(1'b0, ram_word(32'h2000)));
            else if (k == 9) sb.push_back(mke(1'b0, ram_word(32'h2004)));
            else begin
                int j;
                j = (k < 4) ? k : (k < 9) ? k - 1 : k - 2;
                sb.push_back(mke(1'b1, ram_word(32'h1000 + 32'(4 * j))));
            end
        end
        drain(200);

        // stuck BUSY: timeout abort, no hit
        clr(); lat = 0; mode = 1;
        dq.push_back(mkd(1'b0, 1'b0, 32'h500, 32'h0));
        t0 = cyc + 1;
        drain(60);
        chk("to_err_cnt", 32'(err_cnt), 32'd1);
        chk("to_err_time", 32'(last_err - t0), 32'd17);
        chk("to_ren_cycles", 32'(ren_cnt), 32'd16);

        // RAM ERROR: memerr the cycle after the grant
        clr(); mode = 2;
        dq.push_back(mkd(1'b0, 1'b0, 32'h600, 32'h0));
        t0 = cyc + 1;
        drain(20);
        chk("er_err_cnt", 32'(err_cnt), 32'd1);
        chk("er_err_time", 32'(last_err - t0), 32'd2);
        chk("er_ren_cycles", 32'(ren_cnt), 32'd1);

        // fetch withdrawn mid-grant
        clr(); mode = 1;
        iq.push_back(32'h900);
        repeat (3) tick();
        iq.delete();
        repeat (4) tick();
        chk("ab_ren_cycles", 32'(ren_cnt), 32'd3);
        chk("ab_err_cnt", 32'(err_cnt), 32'd0);

        // reset during a data grant, after two streaked data hits
        clr(); mode = 0; lat = 0;
        iq.push_back(32'h700);
        dq.push_back(mkd(1'b0, 1'b0, 32'h800, 32'h0));
        dq.push_back(mkd(1'b0, 1'b0, 32'h804, 32'h0));
        sb.push_back(mke(1'b1, ram_word(32'h800)));
        sb.push_back(mke(1'b1, ram_word(32'h804)));
        for (int n = 0; n < 50 && sb.size() != 0; n++) tick();
        chk("rg_sb", 32'(sb.size()), 32'd0);
        mode = 1;
        dq.push_back(mkd(1'b0, 1'b0, 32'h808, 32'h0));
        repeat (3) tick();
        chk("rg_streak_pre", 32'(dut.dstreak_q), 32'd2);
        chk("rg_ren_pre", 32'(ramREN), 32'd1);
        nRST = 1'b1;
        iq.delete();
        dq.delete();
        tick();
        chk("rg_ctl", 32'({ramREN, ramWEN, ihit, dhit, memerr}), 32'd0);
        chk("rg_addr", ramaddr, 32'd0);
        chk("rg_state", 32'(dut.state_q), 32'd0);
        chk("rg_streak", 32'(dut.dstreak_q), 32'd0);
        nRST = 1'b0; mode = 0;
        repeat (3) tick();
        chk("rg_err_cnt", 32'(err_cnt), 32'd0);
        chk("rg_ren_post", 32'(ramREN), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
